melody_sequencer: RTL and testbench

//  Plays a fixed melody stored in an internal ROM. Sequences the buzzer

---
 rtl/melody_if.sv | 22 ++
 rtl/melody_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_melody_sequencer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/melody_if.sv
// Control and tone-output bundle between a player (host or button logic)
// and the melody sequencer that drives the buzzer wave generator.
interface melody_if #(
  parameter int width = 13
);
  logic             start;
  logic             stop;
  logic [width-1:0] div;
  logic             enable;
  logic             busy;
  logic             done;

  modport master (
    output start, stop,
    input  div, enable, busy, done
  );

  modport slave (
    input  start, stop,
    output div, enable, busy, done
  );
endinterface

// File: rtl/melody_sequencer.sv
// Melody sequencer: steps through a fixed song ROM, one note per entry,
// driving the wave generator divisor and enable at a fixed tempo.
// Optional feature macro: MELODY_GAP_EN adds one silent tick after every
// note so repeated notes are articulated; undefined gives legato playback.
module melody_sequencer #(
  parameter int freq  = 2080000,
  parameter int width = 13,
  parameter int volw  = 1,
  parameter int tick  = 260000,
  parameter int addrw = 4
) (
  input  logic     clk,
  input  logic     rst,
  melody_if.slave  bus
);

  localparam int TW = $clog2(tick);
  localparam logic [TW-1:0] TICK_LAST = TW'(tick - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] PLAY  = 2'd2;
`ifdef MELODY_GAP_EN
  localparam logic [1:0] GAP   = 2'd3;
`endif

  // Divisor for a pitch given in centi-hertz, rounded to the nearest integer.
  function automatic logic [width-1:0] noteDiv(input longint centiHz);
    longint num;
    longint den;
    num = longint'(freq) * 100;
    den = centiHz * (longint'(1) << volw);
    return width'((num + den / 2) / den);
  endfunction

  localparam logic [width-1:0] DIV_C4 = noteDiv(26163);
  localparam logic [width-1:0] DIV_D4 = noteDiv(29366);
  localparam logic [width-1:0] DIV_E4 = noteDiv(32963);
  localparam logic [width-1:0] DIV_F4 = noteDiv(34923);
  localparam logic [width-1:0] DIV_G4 = noteDiv(39200);
  localparam logic [width-1:0] DIV_A4 = noteDiv(44000);
  localparam logic [width-1:0] DIV_B4 = noteDiv(49388);
  localparam logic [width-1:0] DIV_C5 = noteDiv(52325);

  logic [1:0]       state_q, state_d;
  logic [addrw-1:0] addr_q, addr_d;
  logic [TW-1:0]    tickCnt_q, tickCnt_d;
  logic [3:0]       durCnt_q, durCnt_d;
  logic [width-1:0] div_q, div_d;
  logic             enable_q, enable_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [7:0]       entry;
  logic [3:0]       entryCode;
  logic [3:0]       entryDur;
  logic [width-1:0] codeDiv;
  logic             isTone;

  // Song ROM: {code, duration-in-ticks}; a zero duration marks the end.
  always_comb begin
    entry = 8'h00;
    case (int'(addr_q))
      0:       entry = 8'h12;
      1:       entry = 8'h32;
      2:       entry = 8'h52;
      3:       entry = 8'h82;
      4:       entry = 8'h01;
      5:       entry = 8'h84;
      default: entry = 8'h00;
    endcase
  end

  assign entryCode = entry[7:4];
  assign entryDur  = entry[3:0];

  // Pitch decode; codes outside 1..8 play as rests and keep the old divisor.
  always_comb begin
    codeDiv = div_q;
    isTone  = 1'b1;
    case (entryCode)
      4'd1:    codeDiv = DIV_C4;
      4'd2:    codeDiv = DIV_D4;
      4'd3:    codeDiv = DIV_E4;
      4'd4:    codeDiv = DIV_F4;
      4'd5:    codeDiv = DIV_G4;
      4'd6:    codeDiv = DIV_A4;
      4'd7:    codeDiv = DIV_B4;
      4'd8:    codeDiv = DIV_C5;
      default: isTone  = 1'b0;
    endcase
  end

  // Sequencing decisions; stop overrides everything and returns silently to idle.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    tickCnt_d = tickCnt_q;
    durCnt_d  = durCnt_q;
    div_d     = div_q;
    enable_d  = enable_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    if (bus.stop) begin
      state_d  = IDLE;
      enable_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            addr_d  = '0;
            state_d = FETCH;
            busy_d  = 1'b1;
          end
        end
        FETCH: begin
          if (entryDur == 4'd0) begin
            done_d   = 1'b1;
            enable_d = 1'b0;
            busy_d   = 1'b0;
            state_d  = IDLE;
          end else begin
            div_d     = codeDiv;
            enable_d  = isTone;
            durCnt_d  = entryDur;
            tickCnt_d = '0;
            state_d   = PLAY;
          end
        end
        PLAY: begin
          if (tickCnt_q == TICK_LAST) begin
            tickCnt_d = '0;
            durCnt_d  = durCnt_q - 4'd1;
            if (durCnt_q == 4'd1) begin
              addr_d = addr_q + 1'b1;
              if (addr_q == '1) begin
                done_d   = 1'b1;
                enable_d = 1'b0;
                busy_d   = 1'b0;
                state_d  = IDLE;
              end else begin
`ifdef MELODY_GAP_EN
                enable_d = 1'b0;
                state_d  = GAP;
`else
                state_d  = FETCH;
`endif
              end
            end
          end else begin
            tickCnt_d = tickCnt_q + 1'b1;
          end
        end
`ifdef MELODY_GAP_EN
        GAP: begin
          if (tickCnt_q == TICK_LAST) begin
            tickCnt_d = '0;
            state_d   = FETCH;
          end else begin
            tickCnt_d = tickCnt_q + 1'b1;
          end
        end
`endif
        default: begin
          state_d  = IDLE;
          enable_d = 1'b0;
          busy_d   = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      tickCnt_q <= '0;
      durCnt_q  <= '0;
      div_q     <= '0;
      enable_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      tickCnt_q <= tickCnt_d;
      durCnt_q  <= durCnt_d;
      div_q     <= div_d;
      enable_q  <= enable_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.div    = div_q;
  assign bus.enable = enable_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Testbench for melody_sequencer (tick=4): a song-level reference model
// expands each accepted start into the expected per-cycle output trace.
module tb_melody_sequencer;

  localparam int TICK = 4;

  typedef struct packed {
    logic [12:0] div;
    logic        en;
    logic        busy;
    logic        done;
  } outs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  melody_if #(.width(13)) bus ();

  melody_sequencer #(.tick(TICK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    fails  = 0;
  outs_t expQ[$];
  outs_t expNow = '0;
  bit    comparing = 1'b0;

  real noteHz[8] = '{261.63, 293.66, 329.63, 349.23, 392.00, 440.00, 493.88, 523.25};

  // Nearest-integer divisor for a note at 2.08 MHz with a 1-bit volume counter.
  function automatic int refDiv(input int code);
    return $rtoi(2080000.0 / noteHz[code-1] / 2.0 + 0.5);
  endfunction

  function automatic int songCode(input int a);
    case (a)
      0: return 1; 1: return 3; 2: return 5; 3: return 8; 4: return 0; 5: return 8;
      default: return 0;
    endcase
  endfunction

  function automatic int songDur(input int a);
    case (a)
      0: return 2; 1: return 2; 2: return 2; 3: return 2; 4: return 1; 5: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic outs_t mk(input logic [12:0] d, input logic e, input logic b, input logic dn);
    outs_t o;
    o.div = d; o.en = e; o.busy = b; o.done = dn;
    return o;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Expected outputs after each edge of one playback, starting at the start edge.
  task automatic buildPlayback();
    logic [12:0] dv;
    logic        en;
    int          code;
    dv = expNow.div;
    en = expNow.en;
    expQ.delete();
    expQ.push_back(mk(dv, en, 1'b1, 1'b0));
    for (int a = 0; a < 16; a++) begin
      if (songDur(a) == 0) begin
        expQ.push_back(mk(dv, 1'b0, 1'b0, 1'b1));
        break;
      end
      code = songCode(a);
      if (code >= 1 && code <= 8) dv = 13'(refDiv(code));
      en = (code >= 1 && code <= 8);
      repeat (songDur(a) * TICK) expQ.push_back(mk(dv, en, 1'b1, 1'b0));
      if (a == 15) begin
        expQ.push_back(mk(dv, 1'b0, 1'b0, 1'b1));
        break;
      end
`ifdef MELODY_GAP_EN
      en = 1'b0;
      repeat (TICK) expQ.push_back(mk(dv, 1'b0, 1'b1, 1'b0));
`endif
      expQ.push_back(mk(dv, en, 1'b1, 1'b0));
    end
`ifdef MELODY_GAP_EN
    checkOutput("song_len", expQ.size(), 84);
`else
    checkOutput("song_len", expQ.size(), 60);
`endif
  endtask

  // Reference model: advances on every clock edge and on reset assertion.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        expQ.delete();
        expNow = '0;
      end else if (bus.stop) begin
        expQ.delete();
        expNow.en = 1'b0; expNow.busy = 1'b0; expNow.done = 1'b0;
      end else if (expQ.size() > 0) begin
        expNow = expQ.pop_front();
      end else begin
        expNow.done = 1'b0;
        expNow.busy = 1'b0;
        if (bus.start) begin
          buildPlayback();
          expNow = expQ.pop_front();
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (comparing) begin
        checkOutput("div",    int'(bus.div),    int'(expNow.div));
        checkOutput("enable", int'(bus.enable), int'(expNow.en));
        checkOutput("busy",   int'(bus.busy),   int'(expNow.busy));
        checkOutput("done",   int'(bus.done),   int'(expNow.done));
      end
    end
  end

  task automatic stepCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic p);
    bus.start = s;
    bus.stop  = p;
    stepCycle();
  endtask

  task automatic waitDone(input int bound);
    int n = 0;
    while (!bus.done && n < bound) begin
      stepCycle();
      n++;
    end
    checkOutput("done_seen", int'(bus.done), 1);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    rst = 1'b1;
    repeat (3) stepCycle();
    checkOutput("reset_div",  int'(bus.div), 0);
    checkOutput("reset_busy", int'(bus.busy), 0);
    rst = 1'b0;
    comparing = 1'b1;

    checkOutput("pin_c4", refDiv(1), 3975);
    checkOutput("pin_e4", refDiv(3), 3155);
    checkOutput("pin_g4", refDiv(5), 2653);
    checkOutput("pin_c5", refDiv(8), 1988);

    $display("[TB] single start pulse, full song");
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    bus.start = 1'b0;
    checkOutput("t1_busy", int'(bus.busy), 1);
    checkOutput("t1_en_early", int'(bus.enable), 0);
    stepCycle();
    checkOutput("t1_en", int'(bus.enable), 1);
    checkOutput("t1_div", int'(bus.div), 3975);
    waitDone(200);
    stepCycle();
    checkOutput("t2_busy_after", int'(bus.busy), 0);
    checkOutput("t2_last_div", int'(bus.div), 1988);

    $display("[TB] stop during second note");
    applyStimulus(1'b1, 1'b0);
    bus.start = 1'b0;
    repeat (16) stepCycle();
    applyStimulus(1'b0, 1'b1);
    bus.stop = 1'b0;
    checkOutput("t4_en", int'(bus.enable), 0);
    checkOutput("t4_busy", int'(bus.busy), 0);
    checkOutput("t4_div", int'(bus.div), 3155);
    checkOutput("t4_done", int'(bus.done), 0);
    repeat (3) stepCycle();

    $display("[TB] start with stop, and start while busy");
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("t5_busy", int'(bus.busy), 0);
    applyStimulus(1'b1, 1'b0);
    bus.start = 1'b0;
    repeat (5) stepCycle();
    applyStimulus(1'b1, 1'b0);
    bus.start = 1'b0;
    waitDone(200);
    repeat (3) stepCycle();

    $display("[TB] reset mid-note");
    applyStimulus(1'b1, 1'b0);
    bus.start = 1'b0;
    repeat (4) stepCycle();
    rst = 1'b1;
    #1;
    checkOutput("t6_div", int'(bus.div), 0);
    checkOutput("t6_en", int'(bus.enable), 0);
    checkOutput("t6_busy", int'(bus.busy), 0);
    stepCycle();
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0);
    bus.start = 1'b0;
    stepCycle();
    checkOutput("t6_replay_div", int'(bus.div), 3975);
    checkOutput("t6_replay_en", int'(bus.enable), 1);

    $display("[TB] start held through end of song");
    bus.start = 1'b1;
    waitDone(200);
    stepCycle();
    checkOutput("held_restart", int'(bus.busy), 1);
    bus.start = 1'b0;
    applyStimulus(1'b0, 1'b1);
    bus.stop = 1'b0;

    $display("[TB] randomized start/stop");
    for (int i = 0; i < 2500; i++) begin
      applyStimulus(logic'($urandom_range(0, 9) < 3),
                    logic'((i < 1200) && ($urandom_range(0, 99) == 0)));
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    repeat (100) stepCycle();

    comparing = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
